// File: rtl/mul32_pkg.sv
// mul32_pkg: shared state encoding and constants for mul32_seq
package mul32_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE, NEG} state_e;
  localparam int MUL_ITER = 32;
  localparam int CNT_W = 5;
  localparam logic [2:0] ALU_OP_ADD = 3'b110;
endpackage

// File: rtl/alu32.sv
// alu32: 32-bit ALU with carry, negative, zero and overflow flags
module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);
  logic [32:0] sum, diff;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    result = op == 3'b000 ? a & b :
             op == 3'b001 ? a | b :
             op == 3'b010 ? a ^ b :
             op == 3'b011 ? ~(a | b) :
             op == 3'b100 ? a << b[4:0] :
             op == 3'b101 ? a >> b[4:0] :
             op == 3'b110 ? sum[31:0] : diff[31:0];
    c = op == 3'b110 ? sum[32] : op == 3'b111 ? ~diff[32] : 1'b0;
    v = op == 3'b110 ? (a[31] == b[31]) && (result[31] != a[31]) :
        op == 3'b111 ? (a[31] != b[31]) && (result[31] != a[31]) : 1'b0;
    n = result[31];
    z = result == 32'd0;
  end
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32->64 shift-add multiplier on alu32; MUL32_SIGNED_EN adds sgn input and NEG state
module mul32_seq import mul32_pkg::*; #(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef MUL32_SIGNED_EN
  input  logic        sgn,
`endif
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        busy,
  output logic        done
);
  state_e state_q, state_d;
  logic [31:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d, a_in, b_in, alu_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] result_q, result_d, step;
  logic done_q, done_d, sg_q, sg_d, neg_q, neg_d, go, last;
  logic alu_c, alu_unused_n, alu_unused_z, alu_unused_v;
  alu32 u_alu (
    .a(hi_q), .b(mcand_q), .op(ALU_OP_ADD), .result(alu_sum),
    .c(alu_c), .n(alu_unused_n), .z(alu_unused_z), .v(alu_unused_v)
  );
  assign go = state_q == IDLE && start;
  assign last = state_q == CALC && cnt_q == CNT_W'(MUL_ITER - 1);
  assign step = lo_q[0] ? {alu_c, alu_sum, lo_q[31:1]} : {1'b0, hi_q, lo_q[31:1]};
  assign result = result_q;
  assign busy = state_q == CALC || state_q == NEG;
  assign done = done_q;
  always_comb begin
`ifdef MUL32_SIGNED_EN
    a_in = sgn && a[31] ? -a : a;
    b_in = sgn && b[31] ? -b : b;
    sg_d = go ? sgn : sg_q;
    neg_d = go ? sgn && (a[31] ^ b[31]) : neg_q;
`else
    a_in = a;
    b_in = b;
    sg_d = 1'b0;
    neg_d = 1'b0;
`endif
    state_d = go ? CALC : last ? (sg_q ? NEG : DONE) :
              state_q == CALC ? CALC : state_q == NEG ? DONE : IDLE;
    mcand_d = go ? a_in : mcand_q;
    {hi_d, lo_d} = go ? {32'd0, b_in} : state_q == CALC ? step : {hi_q, lo_q};
    cnt_d = go ? '0 : state_q == CALC ? cnt_q + CNT_W'(1) : cnt_q;
    result_d = last && !sg_q ? step :
               state_q == NEG ? (neg_q ? ~{hi_q, lo_q} + 64'd1 : {hi_q, lo_q}) : result_q;
    done_d = state_d == DONE ? 1'b1 : DONE_HOLD && !go ? done_q : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
      sg_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      done_q <= done_d;
      sg_q <= sg_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: scoreboard bench for mul32_seq (define MUL32_SIGNED_EN to cover signed mode)
module tb_mul32_seq;
  typedef struct {
    logic [63:0] res;
    int          due;
    string       nm;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] result;
  logic busy, done;
  int cyc = 0, checks = 0, fails = 0;
  exp_t sb[$];
  mul32_seq dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef MUL32_SIGNED_EN
    .sgn(sgn),
`endif
    .a(a), .b(b), .result(result), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending operation", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_result"}, result, e.res);
        chk({e.nm, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic [63:0] exp, input string nm);
    a = x;
    b = y;
    sgn = s;
    start = 1'b1;
    sb.push_back('{exp, cyc + 33 + (s ? 1 : 0), nm});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_quiet", {result[61:0], busy, done}, 64'd0);
    end
    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "mul_3x5");
    chk("busy_after_start", 64'(busy), 64'd1);
    drain(60);
    chk("busy_after_done", 64'(busy), 64'd0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "mul_max");
    drain(60);
    issue(32'h0001_000F, 32'h0000_0001, 1'b0, 64'h0000_0000_0001_000F, "mul_by_one");
    drain(60);
    issue(32'd0, 32'd12345, 1'b0, 64'd0, "mul_a_zero");
    drain(60);
    issue(32'hDEAD_BEEF, 32'd0, 1'b0, 64'd0, "mul_b_zero");
    drain(60);
    k = cyc;
    a = 32'd7;
    b = 32'd9;
    sgn = 1'b0;
    start = 1'b1;
    sb.push_back('{64'd63, k + 33, "held_7x9"});
    sb.push_back('{64'd1, k + 67, "held_restart"});
    repeat (3) @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    while (cyc < k + 35) @(negedge clk);
    start = 1'b0;
    drain(80);
    k = cyc;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    issue(32'd2, 32'd3, 1'b0, 64'd6, "after_abort");
    drain(60);
`ifdef MUL32_SIGNED_EN
    issue(32'hFFFF_FFFF, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, "signed_m1x5");
    drain(60);
    issue(32'hFFFF_FFFF, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFFB, "unsigned_ffx5");
    drain(60);
    issue(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "signed_minint");
    drain(60);
    issue(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 64'd21, "signed_neg_neg");
    drain(60);
`endif
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mul32_seq.md
Name: mul32_seq

Overview:
- Sequential 32x32 -> 64-bit unsigned shift-add multiplier that sits directly upstream of alu32 and drives it.
- Each iteration drives alu32 with op=ADD (3'b110) and uses its c flag as bit 32 of the partial sum.
- Start/busy/done handshake; one partial-product step per clock.

Parameters:
- DONE_HOLD, 0, 0: done is a single-cycle pulse. 1: done stays high until the next accepted start or reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  multiplicand, captured on accepted start
- b  input  32  multiplier, captured on accepted start
- result  output  64  product; valid when done; held until next accepted start
- busy  output  1  high while in CALC (and NEG when the feature is enabled)
- done  output  1  completion indicator, per DONE_HOLD

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. While reset is high at a clk edge: state=IDLE, result=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation; no partial result is kept.
- Registers: mcand[31:0], hi[31:0], lo[31:0], cnt[4:0].
- alu32 hookup: a=hi, b=mcand, op=3'b110 at all times. Only result and c are used; n, z, v are ignored.
- IDLE:
  - busy=0.
  - start=1 at edge E0: mcand<=a, hi<=0, lo<=b, cnt<=0, next state CALC, busy=1 from E0.
  - If DONE_HOLD=1, done clears at E0.
- CALC, at each edge E1..E32:
  - If lo[0]=1: {hi,lo} <= {c, alu_result, lo[31:1]}.
  - Else: {hi,lo} <= {1'b0, hi, lo[31:1]}.
  - cnt increments each step. The step taken when cnt==31 (E32) loads result<={hi',lo'} and moves to DONE.
- DONE:
  - busy=0, done=1 for the cycle after E32. Next state IDLE.
  - DONE_HOLD=1: done stays 1 in IDLE until the next accepted start.
- Latency: done is high in the cycle following the 32nd edge after the start-sampling edge. A start sampled in that DONE cycle is ignored; the earliest restart is the following cycle.
- start while busy or in DONE: ignored. The a and b inputs are not re-sampled.
- Operand values:
  - b=0 or a=0: full 32 steps still run; result=0.
  - Max operands: carry-out is never lost because c feeds hi[31] on the shift.
- result changes only at the DONE-entry edge (or NEG exit) and at reset.

Optional Feature:
- Macro: MUL32_SIGNED_EN
- With it:
  - Extra input port sgn (1 bit), sampled with start.
  - If sgn=1, the absolute values of a and b are loaded, and the sign bit neg = a[31]^b[31] is stored.
  - After CALC, a NEG state (1 cycle, busy=1) applies result <= ~P+1 when neg=1; otherwise P passes through.
  - Signed latency is +1 cycle always when sgn=1. Note |-2^31| loads as 32'h80000000 unsigned, which is correct.
- Without it: no sgn port, no NEG state, unsigned only.

Decomposition:
- Shared package mul32_pkg:
  - state encoding (IDLE, CALC, DONE, NEG)
  - MUL_ITER=32
  - ALU_OP_ADD=3'b110
  - CNT_W=5
- Sub-module: the existing alu32 is instantiated as the adder datapath. No new sub-module.

Test Plan:
- Reset: hold reset 2 cycles -> result=0, busy=0, done=0. Then with start=0 nothing changes for 40 cycles.
- a=3, b=5, start pulse -> busy for 32 cycles, done high exactly 33 edges after E0, result=64'h0000_0000_0000_000F.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> result=64'hFFFF_FFFE_0000_0001 (exercises the c path). Also a=32'h0001_000F, b=32'h0000_0001 -> 64'h0000_0000_0001_000F.
- Start held high for the whole operation with a=7, b=9, then changed to a=1, b=1 mid-CALC -> result=64'd63. In DONE_HOLD=0 a second operation starts only in the first IDLE cycle after done.
- Reset asserted at CALC step 10 -> next cycle IDLE, result=0, busy=0. Then a=2, b=3 -> result=6 with normal latency.
- MUL32_SIGNED_EN, sgn=1, a=32'hFFFF_FFFF, b=5 -> result=64'hFFFF_FFFF_FFFF_FFFB, done at 34 edges after E0. sgn=0 with the same operands -> 64'h0000_0004_FFFF_FFFB.
